// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the MIPS CPU bus arbiter: FSM state encoding, the
// per-requester bus request bundle and the requester index constants.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
  } bus_req_t;

  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  function automatic logic req_pending(input bus_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Avalon-style memory port. The CPU-side requesters and the memory both use
// this bundle; master drives the strobes, slave answers with stall/data.
interface mips_cpu_bus_arbiter_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output read, write, addr, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, addr, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mips_cpu_bus_arb_pick.sv
// Winner selection between instruction fetch (m0) and data (m1) requests.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie, grant the requester that did
// not win last; otherwise m1 always wins a tie.
module mips_cpu_bus_arb_pick
  import mips_cpu_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic valid,
  output logic winner
);

  logic tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_winner = ~last_winner;
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner;
  assign tie_winner         = REQ_DATA;
`endif

  // Single requests win outright; only a tie consults the policy.
  always_comb begin
    valid  = req0 | req1;
    winner = REQ_INSTR;
    if (req0 && req1) begin
      winner = tie_winner;
    end else if (req1) begin
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-requester arbiter for the shared memory bus. One transaction per grant,
// an IDLE cycle between transactions, and a stall watchdog that aborts a
// transaction after TIMEOUT_CYCLES stalled BUSY cycles (0 disables it).
// Optional macro ARB_ROUND_ROBIN_EN selects tie-breaking in the pick block.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mips_cpu_bus_arbiter_if.slave  m0,
  mips_cpu_bus_arbiter_if.slave  m1,
  mips_cpu_bus_arbiter_if.master s,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_t       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bus_req_t req0, req1, gnt_req;
  logic     pick_valid, pick_winner;
  logic     strobe_rd, strobe_wr, stalled, accept, timeout_hit;
  logic     unused_s_rdv;

  assign req0 = '{read: m0.read, write: m0.write, addr: m0.addr,
                  byteenable: m0.byteenable, writedata: m0.writedata};
  assign req1 = '{read: m1.read, write: m1.write, addr: m1.addr,
                  byteenable: m1.byteenable, writedata: m1.writedata};
  assign gnt_req = grant_q ? req1 : req0;

  // Read wins over write when a requester asserts both.
  assign strobe_rd   = (state_q == BUSY) && gnt_req.read;
  assign strobe_wr   = (state_q == BUSY) && gnt_req.write && !gnt_req.read;
  assign stalled     = (strobe_rd || strobe_wr) && s.waitrequest;
  assign accept      = (strobe_rd || strobe_wr) && !s.waitrequest;
  assign timeout_hit = TO_EN && stalled && (cnt_q == TO_LIMIT);

  assign unused_s_rdv = s.readdatavalid;

  mips_cpu_bus_arb_pick u_pick (
    .req0        (req_pending(req0)),
    .req1        (req_pending(req1)),
    .last_winner (last_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // State register, grant, last winner and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= REQ_INSTR;
      last_q  <= REQ_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, finish or abort in BUSY, one RESP beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_winner;
          last_d  = pick_winner;
        end
      end
      BUSY: begin
        if (accept) begin
          state_d = strobe_rd ? RESP : IDLE;
        end else if (!stalled) begin
          // Granted requester withdrew: nothing to wait for.
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: slave strobes from the granted requester, stall/data routing.
  always_comb begin
    s.read       = strobe_rd;
    s.write      = strobe_wr;
    s.addr       = '0;
    s.byteenable = '0;
    s.writedata  = '0;
    if (state_q == BUSY) begin
      s.addr       = gnt_req.addr;
      s.byteenable = gnt_req.byteenable;
      s.writedata  = gnt_req.writedata;
    end

    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    m0.readdata      = '0;
    m1.readdata      = '0;
    m0.readdatavalid = 1'b0;
    m1.readdatavalid = 1'b0;
    timeout          = timeout_hit;

    if (strobe_wr && accept) begin
      if (grant_q) m1.waitrequest = 1'b0;
      else         m0.waitrequest = 1'b0;
    end
    if (state_q == RESP) begin
      if (grant_q) begin
        m1.waitrequest   = 1'b0;
        m1.readdatavalid = 1'b1;
        m1.readdata      = s.readdata;
      end else begin
        m0.waitrequest   = 1'b0;
        m0.readdatavalid = 1'b1;
        m0.readdata      = s.readdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter with a word-wide memory model.
// Built with TIMEOUT_CYCLES=4; tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_mips_cpu_bus_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic stall   = 1'b0;
  logic preload = 1'b0;
  logic timeout;

  int checks = 0;
  int errors = 0;
  int wr_count;
  logic [31:0] mem [0:255];

  mips_cpu_bus_arbiter_if m0_if ();
  mips_cpu_bus_arbiter_if m1_if ();
  mips_cpu_bus_arbiter_if s_if ();

  assign s_if.waitrequest   = stall;
  assign s_if.readdatavalid = 1'b0;

  mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Memory: registered read data one cycle after accept, counts accepted writes.
  always @(posedge clk) begin
    if (preload) begin
      mem[8'h40] <= 32'h12345678;
      wr_count   <= 0;
    end else begin
      if (s_if.write && !s_if.waitrequest) begin
        mem[s_if.addr[9:2]] <= merge(mem[s_if.addr[9:2]], s_if.writedata, s_if.byteenable);
        wr_count <= wr_count + 1;
      end
      if (s_if.read && !s_if.waitrequest) s_if.readdata <= mem[s_if.addr[9:2]];
    end
  end

  task automatic idle_inputs();
    m0_if.read = 0; m0_if.write = 0; m0_if.addr = 0; m0_if.byteenable = 0; m0_if.writedata = 0;
    m1_if.read = 0; m1_if.write = 0; m1_if.addr = 0; m1_if.byteenable = 0; m1_if.writedata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    stall = 0;
    preload = 1;
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (s_if.read !== 1'b0) begin errors++; $display("FAIL rst_s_read got %0h exp 0", s_if.read); end
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL rst_s_write got %0h exp 0", s_if.write); end
    checks++; if (s_if.addr !== 32'h0) begin errors++; $display("FAIL rst_s_addr got %0h exp 0", s_if.addr); end
    checks++; if (s_if.byteenable !== 4'h0) begin errors++; $display("FAIL rst_s_be got %0h exp 0", s_if.byteenable); end
    checks++; if (s_if.writedata !== 32'h0) begin errors++; $display("FAIL rst_s_wd got %0h exp 0", s_if.writedata); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got %0h exp 1", m0_if.waitrequest); end
    checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait got %0h exp 1", m1_if.waitrequest); end
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_m0_rdv got %0h exp 0", m0_if.readdatavalid); end
    checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_m1_rdv got %0h exp 0", m1_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rdata got %0h exp 0", m0_if.readdata); end
    checks++; if (m1_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_m1_rdata got %0h exp 0", m1_if.readdata); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0h exp 0", timeout); end
    preload = 0;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_m0();
    m0_if.read = 1; m0_if.addr = 32'h100; m0_if.byteenable = 4'hF;
    @(negedge clk);
    checks++; if (s_if.read !== 1'b0) begin errors++; $display("FAIL rd_c1_s_read got %0h exp 0", s_if.read); end
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL rd_c2_s_read got %0h exp 1", s_if.read); end
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL rd_c2_s_write got %0h exp 0", s_if.write); end
    checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL rd_c2_s_addr got %0h exp 100", s_if.addr); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rd_c2_m0_wait got %0h exp 1", m0_if.waitrequest); end
    @(posedge clk); #1;
    m0_if.read = 0;
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_c3_m0_rdv got %0h exp 1", m0_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'h12345678) begin errors++; $display("FAIL rd_c3_m0_rdata got %0h exp 12345678", m0_if.readdata); end
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rd_c3_m0_wait got %0h exp 0", m0_if.waitrequest); end
    checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_c3_m1_rdv got %0h exp 0", m1_if.readdatavalid); end
    checks++; if (m1_if.readdata !== 32'h0) begin errors++; $display("FAIL rd_c3_m1_rdata got %0h exp 0", m1_if.readdata); end
    checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rd_c3_m1_wait got %0h exp 1", m1_if.waitrequest); end
    @(posedge clk); @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_c4_m0_rdv got %0h exp 0", m0_if.readdatavalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    m0_if.read = 1; m0_if.addr = 32'h100; m0_if.byteenable = 4'hF;
    m1_if.write = 1; m1_if.addr = 32'h200; m1_if.writedata = 32'hDEADBEEF; m1_if.byteenable = 4'hF;
    @(negedge clk);
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL pri_c1_s_write got %0h exp 0", s_if.write); end
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.write !== 1'b1) begin errors++; $display("FAIL pri_c2_s_write got %0h exp 1", s_if.write); end
    checks++; if (s_if.read !== 1'b0) begin errors++; $display("FAIL pri_c2_s_read got %0h exp 0", s_if.read); end
    checks++; if (s_if.addr !== 32'h200) begin errors++; $display("FAIL pri_c2_s_addr got %0h exp 200", s_if.addr); end
    checks++; if (s_if.writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL pri_c2_s_wd got %0h exp deadbeef", s_if.writedata); end
    checks++; if (s_if.byteenable !== 4'hF) begin errors++; $display("FAIL pri_c2_s_be got %0h exp f", s_if.byteenable); end
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL pri_c2_m1_wait got %0h exp 0", m1_if.waitrequest); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL pri_c2_m0_wait got %0h exp 1", m0_if.waitrequest); end
    @(posedge clk); #1;
    m1_if.write = 0;
    @(negedge clk);
    checks++; if (s_if.read !== 1'b0) begin errors++; $display("FAIL pri_c3_idle_s_read got %0h exp 0", s_if.read); end
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL pri_c4_s_read got %0h exp 1", s_if.read); end
    checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL pri_c4_s_addr got %0h exp 100", s_if.addr); end
    @(posedge clk); #1;
    m0_if.read = 0;
    @(negedge clk);
    checks++; if (m0_if.readdata !== 32'h12345678) begin errors++; $display("FAIL pri_c5_m0_rdata got %0h exp 12345678", m0_if.readdata); end
    @(posedge clk); #1;
    m0_if.read = 1; m0_if.addr = 32'h200;
    @(posedge clk); @(posedge clk); #1;
    m0_if.read = 0;
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL pri_rb_m0_rdv got %0h exp 1", m0_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pri_rb_m0_rdata got %0h exp deadbeef", m0_if.readdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_tie_sequence();
    logic [3:0] exp_m1;
    logic [1:0] got, exp;
`ifdef ARB_ROUND_ROBIN_EN
    exp_m1 = 4'b0101;
`else
    exp_m1 = 4'b1111;
`endif
    m0_if.write = 1; m0_if.addr = 32'h300; m0_if.writedata = 32'h0000AAAA; m0_if.byteenable = 4'hF;
    m1_if.write = 1; m1_if.addr = 32'h304; m1_if.writedata = 32'h0000BBBB; m1_if.byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      @(posedge clk); @(negedge clk);
      got = {!m1_if.waitrequest, !m0_if.waitrequest};
      exp = exp_m1[k] ? 2'b10 : 2'b01;
      checks++; if (got !== exp) begin errors++; $display("FAIL tie_grant_%0d got %b exp %b", k, got, exp); end
      @(posedge clk);
    end
    #1;
    m0_if.write = 0; m1_if.write = 0;
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL tie_dropped_granted got %0h exp 0", s_if.write); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_precedence();
    int wc0;
    wc0 = wr_count;
    m1_if.read = 1; m1_if.write = 1; m1_if.addr = 32'h100;
    m1_if.writedata = 32'hFFFFFFFF; m1_if.byteenable = 4'hF;
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL prec_s_read got %0h exp 1", s_if.read); end
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL prec_s_write got %0h exp 0", s_if.write); end
    @(posedge clk); #1;
    m1_if.read = 0; m1_if.write = 0;
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL prec_m1_rdv got %0h exp 1", m1_if.readdatavalid); end
    checks++; if (m1_if.readdata !== 32'h12345678) begin errors++; $display("FAIL prec_m1_rdata got %0h exp 12345678", m1_if.readdata); end
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL prec_m0_rdv got %0h exp 0", m0_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'h0) begin errors++; $display("FAIL prec_m0_rdata got %0h exp 0", m0_if.readdata); end
    @(posedge clk); #1;
    checks++; if (wr_count !== wc0) begin errors++; $display("FAIL prec_no_write got %0d exp %0d", wr_count, wc0); end
  endtask

  task automatic test_stall_write();
    int wc0;
    wc0 = wr_count;
    stall = 1;
    m1_if.write = 1; m1_if.addr = 32'h204; m1_if.writedata = 32'hCAFEF00D; m1_if.byteenable = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL stall_%0d_m1_wait got %0h exp 1", i, m1_if.waitrequest); end
      checks++; if (s_if.write !== 1'b1) begin errors++; $display("FAIL stall_%0d_s_write got %0h exp 1", i, s_if.write); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stall_%0d_timeout got %0h exp 0", i, timeout); end
    end
    @(posedge clk); #1;
    stall = 0;
    @(negedge clk);
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL stall_acc_m1_wait got %0h exp 0", m1_if.waitrequest); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stall_acc_timeout got %0h exp 0", timeout); end
    @(posedge clk); #1;
    m1_if.write = 0;
    checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL stall_write_count got %0d exp %0d", wr_count, wc0 + 1); end
    checks++; if (mem[8'h81] !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_mem got %0h exp cafef00d", mem[8'h81]); end
  endtask

  task automatic test_timeout();
    int wc0;
    wc0 = wr_count;
    stall = 1;
    m0_if.write = 1; m0_if.addr = 32'h208; m0_if.writedata = 32'h11112222; m0_if.byteenable = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_busy%0d_timeout got %0h exp 0", i, timeout); end
      checks++; if (s_if.write !== 1'b1) begin errors++; $display("FAIL to_busy%0d_s_write got %0h exp 1", i, s_if.write); end
    end
    @(posedge clk); @(negedge clk);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %0h exp 1", timeout); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL to_pulse_m0_wait got %0h exp 1", m0_if.waitrequest); end
    @(posedge clk); @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_after_timeout got %0h exp 0", timeout); end
    checks++; if (s_if.write !== 1'b0) begin errors++; $display("FAIL to_after_s_write got %0h exp 0", s_if.write); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL to_after_m0_wait got %0h exp 1", m0_if.waitrequest); end
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.write !== 1'b1) begin errors++; $display("FAIL to_retry_s_write got %0h exp 1", s_if.write); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_retry_timeout got %0h exp 0", timeout); end
    @(posedge clk); #1;
    stall = 0;
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL to_retry_m0_wait got %0h exp 0", m0_if.waitrequest); end
    @(posedge clk); #1;
    m0_if.write = 0;
    checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL to_write_count got %0d exp %0d", wr_count, wc0 + 1); end
  endtask

  task automatic test_reset_mid();
    stall = 1;
    m0_if.read = 1; m0_if.addr = 32'h100; m0_if.byteenable = 4'hF;
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL rmid_busy_s_read got %0h exp 1", s_if.read); end
    #2 reset_n = 0;
    #1;
    checks++; if (s_if.read !== 1'b0) begin errors++; $display("FAIL rmid_s_read got %0h exp 0", s_if.read); end
    checks++; if (s_if.addr !== 32'h0) begin errors++; $display("FAIL rmid_s_addr got %0h exp 0", s_if.addr); end
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rmid_m0_wait got %0h exp 1", m0_if.waitrequest); end
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rmid_m0_rdv got %0h exp 0", m0_if.readdatavalid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %0h exp 0", timeout); end
    stall = 0;
    @(posedge clk); @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rmid_held_rdv got %0h exp 0", m0_if.readdatavalid); end
    reset_n = 1;
    @(posedge clk); @(negedge clk);
    checks++; if (s_if.read !== 1'b1) begin errors++; $display("FAIL rmid_fresh_s_read got %0h exp 1", s_if.read); end
    @(posedge clk); #1;
    m0_if.read = 0;
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL rmid_fresh_rdv got %0h exp 1", m0_if.readdatavalid); end
    checks++; if (m0_if.readdata !== 32'h12345678) begin errors++; $display("FAIL rmid_fresh_rdata got %0h exp 12345678", m0_if.readdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_priority();
    test_tie_sequence();
    test_read_precedence();
    test_stall_write();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
